wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 24 ++
 rtl/wb_stage_if.sv | 41 ++++
 rtl/wb_stage_load_align.sv | 34 +++
 rtl/wb_stage.sv | 97 +++++++++
 tb/tb_wb_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared core package for the writeback stage: result-select and load-size
// encodings plus the stage FSM state type.
package wb_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_ALT  = 2'b11;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;

  typedef logic [0:0] wb_state_t;
  localparam wb_state_t ST_IDLE      = 1'b0;
  localparam wb_state_t ST_WAIT_LOAD = 1'b1;

endpackage

// File: rtl/wb_stage_if.sv
// EX/MEM -> WB handshake, load response and register-file write port.
// Optional forwarding outputs exist only when WB_BYPASS_EN is defined.
interface wb_stage_if #(parameter int unsigned XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd_addr;
  logic            in_reg_write;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rsp_data;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            reg_write;
  logic            busy;
`ifdef WB_BYPASS_EN
  logic            fwd_valid;
  logic [4:0]      fwd_rd_addr;
  logic [XLEN-1:0] fwd_data;
`endif

  modport master (
`ifdef WB_BYPASS_EN
    input  fwd_valid, fwd_rd_addr, fwd_data,
`endif
    output in_valid, in_rd_addr, in_reg_write, in_wb_sel, in_funct3,
    output in_alu_result, in_pc_plus4, dmem_rsp_valid, dmem_rsp_data,
    input  in_ready, rd_addr, rd_data, reg_write, busy
  );

  modport slave (
`ifdef WB_BYPASS_EN
    output fwd_valid, fwd_rd_addr, fwd_data,
`endif
    input  in_valid, in_rd_addr, in_reg_write, in_wb_sel, in_funct3,
    input  in_alu_result, in_pc_plus4, dmem_rsp_valid, dmem_rsp_data,
    output in_ready, rd_addr, rd_data, reg_write, busy
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: picks the addressed lane out of an aligned doubleword and
// sign/zero-extends it according to the load funct3.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Unaligned low address bits are simply dropped for wider accesses.
  always_comb begin
    byte_v = data[{addr_lo, 3'b000} +: 8];
    half_v = data[{addr_lo[2:1], 4'b0000} +: 16];
    word_v = data[{addr_lo[2], 5'b00000} +: 32];
    unique case (funct3)
      FUNCT3_LB:  result = {{(XLEN-8){byte_v[7]}}, byte_v};
      FUNCT3_LH:  result = {{(XLEN-16){half_v[15]}}, half_v};
      FUNCT3_LW:  result = {{(XLEN-32){word_v[31]}}, word_v};
      FUNCT3_LBU: result = {{(XLEN-8){1'b0}}, byte_v};
      FUNCT3_LHU: result = {{(XLEN-16){1'b0}}, half_v};
      FUNCT3_LWU: result = {{(XLEN-32){1'b0}}, word_v};
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: single-cycle ALU/link writeback, two-state wait for loads.
// Define WB_BYPASS_EN to expose next-edge forwarding outputs.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  wb_state_t       state, nxt_state;
  logic [4:0]      rd_addr_q, nxt_rd_addr;
  logic [XLEN-1:0] rd_data_q, nxt_rd_data;
  logic            reg_write_q, nxt_reg_write;

  logic [4:0]      ld_rd_q, nxt_ld_rd;
  logic            ld_we_q, nxt_ld_we;
  logic [2:0]      ld_funct3_q, nxt_ld_funct3;
  logic [2:0]      ld_addr_q, nxt_ld_addr;
  logic [XLEN-1:0] load_value;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3  (ld_funct3_q),
    .addr_lo (ld_addr_q),
    .data    (bus.dmem_rsp_data),
    .result  (load_value)
  );

  always_comb begin
    nxt_state     = state;
    nxt_rd_addr   = rd_addr_q;
    nxt_rd_data   = rd_data_q;
    nxt_reg_write = 1'b0;
    nxt_ld_rd     = ld_rd_q;
    nxt_ld_we     = ld_we_q;
    nxt_ld_funct3 = ld_funct3_q;
    nxt_ld_addr   = ld_addr_q;
    if (state == ST_IDLE) begin
      if (bus.in_valid) begin
        if (bus.in_wb_sel == WB_SEL_LOAD) begin
          nxt_state     = ST_WAIT_LOAD;
          nxt_ld_rd     = bus.in_rd_addr;
          nxt_ld_we     = bus.in_reg_write;
          nxt_ld_funct3 = bus.in_funct3;
          nxt_ld_addr   = bus.in_alu_result[2:0];
        end else begin
          nxt_rd_addr   = bus.in_rd_addr;
          nxt_rd_data   = (bus.in_wb_sel == WB_SEL_PC4) ? bus.in_pc_plus4
                                                        : bus.in_alu_result;
          nxt_reg_write = bus.in_reg_write && (bus.in_rd_addr != 5'd0);
        end
      end
    end else if (bus.dmem_rsp_valid) begin
      nxt_state     = ST_IDLE;
      nxt_rd_addr   = ld_rd_q;
      nxt_rd_data   = load_value;
      nxt_reg_write = ld_we_q && (ld_rd_q != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      reg_write_q <= 1'b0;
      ld_rd_q     <= '0;
      ld_we_q     <= 1'b0;
      ld_funct3_q <= '0;
      ld_addr_q   <= '0;
    end else begin
      state       <= nxt_state;
      rd_addr_q   <= nxt_rd_addr;
      rd_data_q   <= nxt_rd_data;
      reg_write_q <= nxt_reg_write;
      ld_rd_q     <= nxt_ld_rd;
      ld_we_q     <= nxt_ld_we;
      ld_funct3_q <= nxt_ld_funct3;
      ld_addr_q   <= nxt_ld_addr;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state == ST_WAIT_LOAD);
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.reg_write = reg_write_q;

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid   = nxt_reg_write;
  assign bus.fwd_rd_addr = nxt_rd_addr;
  assign bus.fwd_data    = nxt_rd_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_wb_stage;
  import wb_stage_pkg::*;

  typedef struct {
    bit          busy;
    bit          we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [4:0]  p_rd;
    bit          p_we;
    logic [2:0]  p_f3;
    logic [2:0]  p_addr;
  } model_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     tests = 0;
  int     fails = 0;
  model_t m;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(64)) bus ();

  wb_stage #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] load_val(input logic [2:0] f3, input logic [2:0] a,
                                           input logic [63:0] d);
    logic [63:0] b, h, w;
    b = d >> (8 * a);
    h = d >> (16 * (a >> 1));
    w = d >> (32 * a[2]);
    case (f3)
      3'b000:  return longint'(byte'(b));
      3'b001:  return longint'(shortint'(h));
      3'b010:  return longint'(int'(w));
      3'b100:  return 64'(b[7:0]);
      3'b101:  return 64'(h[15:0]);
      3'b110:  return 64'(w[31:0]);
      default: return d;
    endcase
  endfunction

  // What the stage must look like after the next edge, given current inputs.
  function automatic model_t step_model(input model_t cur);
    model_t n;
    n = cur;
    n.we = 1'b0;
    if (!cur.busy && bus.in_valid) begin
      if (bus.in_wb_sel == 2'b01) begin
        n.busy   = 1'b1;
        n.p_rd   = bus.in_rd_addr;
        n.p_we   = bus.in_reg_write;
        n.p_f3   = bus.in_funct3;
        n.p_addr = bus.in_alu_result[2:0];
      end else begin
        n.rd   = bus.in_rd_addr;
        n.data = (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result;
        n.we   = bus.in_reg_write && (bus.in_rd_addr != 0);
      end
    end else if (cur.busy && bus.dmem_rsp_valid) begin
      n.busy = 1'b0;
      n.rd   = cur.p_rd;
      n.data = load_val(cur.p_f3, cur.p_addr, bus.dmem_rsp_data);
      n.we   = cur.p_we && (cur.p_rd != 0);
    end
    return n;
  endfunction

  always @(negedge clk) begin
    check("in_ready", 64'(bus.in_ready), 64'(!m.busy));
    check("busy", 64'(bus.busy), 64'(m.busy));
    check("reg_write", 64'(bus.reg_write), 64'(m.we));
    check("rd_addr", 64'(bus.rd_addr), 64'(m.rd));
    check("rd_data", bus.rd_data, m.data);
`ifdef WB_BYPASS_EN
    begin
      model_t f;
      f = step_model(m);
      check("fwd_valid", 64'(bus.fwd_valid), 64'(f.we));
      if (f.we) begin
        check("fwd_rd_addr", 64'(bus.fwd_rd_addr), 64'(f.rd));
        check("fwd_data", bus.fwd_data, f.data);
      end
    end
`endif
  end

  task automatic cycle();
    model_t n;
    n = step_model(m);
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic drive(input bit v, input logic [4:0] rd, input bit we, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] pc4,
                       input bit rv, input logic [63:0] rdat);
    bus.in_valid       = v;
    bus.in_rd_addr     = rd;
    bus.in_reg_write   = we;
    bus.in_wb_sel      = sel;
    bus.in_funct3      = f3;
    bus.in_alu_result  = alu;
    bus.in_pc_plus4    = pc4;
    bus.dmem_rsp_valid = rv;
    bus.dmem_rsp_data  = rdat;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 64'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [63:0] val);
    drive(1'b1, rd, 1'b1, WB_SEL_ALU, 3'b000, val, 64'hDEAD, 1'b0, 64'h0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [4:0] rd, input bit we,
                      input logic [63:0] addr);
    drive(1'b1, rd, we, WB_SEL_LOAD, f3, addr, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic rsp(input logic [63:0] d);
    drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 64'h0, 64'h0, 1'b1, d);
  endtask

  initial begin
    m = '{default: '0};
    bus.in_valid = 1'b0; bus.in_rd_addr = '0; bus.in_reg_write = 1'b0;
    bus.in_wb_sel = '0; bus.in_funct3 = '0; bus.in_alu_result = '0;
    bus.in_pc_plus4 = '0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_rd_data", bus.rd_data, 64'h0);
    rst_n = 1'b1;

    alu_op(5'd5, 64'h1234);
    check("alu_we", 64'(bus.reg_write), 64'd1);
    check("alu_rd", 64'(bus.rd_addr), 64'd5);
    check("alu_data", bus.rd_data, 64'h1234);
    idle();
    check("alu_pulse_end", 64'(bus.reg_write), 64'd0);
    check("alu_hold", bus.rd_data, 64'h1234);

    load(FUNCT3_LB, 5'd7, 1'b1, 64'h0000_0000_0000_1003);
    check("lb_accept_we", 64'(bus.reg_write), 64'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      idle();
      check("lb_wait_busy", 64'(bus.busy), 64'd1);
      check("lb_wait_ready", 64'(bus.in_ready), 64'd0);
    end
    rsp(64'h0000_0000_80FF_0000);
    check("lb_data", bus.rd_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_we", 64'(bus.reg_write), 64'd1);
    check("lb_busy_clr", 64'(bus.busy), 64'd0);

    load(FUNCT3_LHU, 5'd8, 1'b1, 64'h0000_0000_0000_2006);
    rsp(64'hBEEF_0000_0000_0000);
    check("lhu_data", bus.rd_data, 64'h0000_0000_0000_BEEF);
    load(FUNCT3_LW, 5'd9, 1'b1, 64'h0000_0000_0000_3004);
    rsp(64'h8000_0000_0000_0000);
    check("lw_data", bus.rd_data, 64'hFFFF_FFFF_8000_0000);

    drive(1'b1, 5'd0, 1'b1, WB_SEL_PC4, 3'b000, 64'h55, 64'h100, 1'b0, 64'h0);
    check("jal_rd0_we", 64'(bus.reg_write), 64'd0);
    drive(1'b1, 5'd1, 1'b1, WB_SEL_PC4, 3'b000, 64'h55, 64'h100, 1'b0, 64'h0);
    check("jal_link", bus.rd_data, 64'h100);

    load(FUNCT3_LD, 5'd10, 1'b1, 64'h40);
    rst_n = 1'b0;
    m = '{default: '0};
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp(64'h1111_2222_3333_4444);
    check("rst_drop_we", 64'(bus.reg_write), 64'd0);
    check("rst_drop_ready", 64'(bus.in_ready), 64'd1);

    rsp(64'hFFFF_FFFF_FFFF_FFFF);
    check("idle_rsp_we", 64'(bus.reg_write), 64'd0);

    for (int unsigned i = 0; i < 6; i++) begin
      alu_op(5'(i + 1), 64'(i * 32'h11 + 1));
      check("b2b_we", 64'(bus.reg_write), 64'd1);
    end

    // Stalled upstream: a held ALU op is ignored until the load returns.
    load(FUNCT3_LBU, 5'd11, 1'b1, 64'h1);
    drive(1'b1, 5'd12, 1'b1, WB_SEL_ALU, 3'b000, 64'h77, 64'h0, 1'b0, 64'h0);
    drive(1'b1, 5'd12, 1'b1, WB_SEL_ALU, 3'b000, 64'h77, 64'h0, 1'b1, 64'h0000_0000_0000_9A00);
    check("lbu_data", bus.rd_data, 64'h9A);
    alu_op(5'd12, 64'h77);
    load(FUNCT3_LH, 5'd13, 1'b1, 64'h3);
    rsp(64'h0000_0000_8001_0000);
    check("lh_unaligned", bus.rd_data, 64'hFFFF_FFFF_FFFF_8001);
    load(FUNCT3_LWU, 5'd14, 1'b1, 64'h4);
    rsp(64'hF000_0001_0000_0000);
    load(3'b111, 5'd15, 1'b1, 64'h5);
    rsp(64'h0123_4567_89AB_CDEF);
    load(FUNCT3_LD, 5'd0, 1'b1, 64'h0);
    rsp(64'h5);
    load(FUNCT3_LB, 5'd16, 1'b0, 64'h0);
    rsp(64'h7F);
    drive(1'b1, 5'd17, 1'b1, WB_SEL_ALT, 3'b000, 64'hABCD, 64'h200, 1'b0, 64'h0);
    check("sel11_alu", bus.rd_data, 64'hABCD);
    drive(1'b1, 5'd18, 1'b0, WB_SEL_ALU, 3'b000, 64'h999, 64'h0, 1'b0, 64'h0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
